// File: rtl/log_scale_pkg.sv
// log_scale_pkg: shared defaults, fp16 field constants and encodings for the log-domain mul/div block
package log_scale_pkg;
  localparam int DEF_EXP_LEN = 5;
  localparam int DEF_MANT_LEN = 10;
  localparam int DEF_LUT_AW = 7;
  localparam int FP16_EXP_LEN = 5;
  localparam int FP16_MANT_LEN = 10;
  localparam int FP16_LEN = 16;
  localparam logic [15:0] FP16_QNAN = 16'h7E00;
  localparam logic [15:0] FP16_INF = 16'h7C00;
  typedef enum logic {OP_MUL = 1'b0, OP_DIV = 1'b1} op_e;
  typedef enum logic {LUT_LOG2 = 1'b0, LUT_EXP2 = 1'b1} lut_sel_e;
  typedef enum logic [1:0] {SP_NONE, SP_ZERO, SP_INF, SP_NAN} sp_e;
endpackage

// File: rtl/lut_ram_2r1w.sv
// lut_ram_2r1w: table RAM with one synchronous write port and two combinational read ports
module lut_ram_2r1w #(
  parameter int DEPTH = 128,
  parameter int WIDTH = 10,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic clk,
  input  logic wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0] rd_addr0,
  input  logic [AW-1:0] rd_addr1,
  output logic [WIDTH-1:0] rd_data0,
  output logic [WIDTH-1:0] rd_data1
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (wr_en) mem[wr_addr] <= wr_data;
  assign rd_data0 = mem[rd_addr0];
  assign rd_data1 = mem[rd_addr1];
endmodule

// File: rtl/log_scale_muldiv.sv
// log_scale_muldiv: 3-stage floating-point multiply/divide done as add/subtract in the log2 domain
module log_scale_muldiv
  import log_scale_pkg::*;
#(
  parameter int EXP_LEN = DEF_EXP_LEN,
  parameter int MANT_LEN = DEF_MANT_LEN,
  parameter int LUT_AW = DEF_LUT_AW,
  localparam int FLOAT_LEN = 1 + EXP_LEN + MANT_LEN
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  output logic in_ready,
  input  logic [FLOAT_LEN-1:0] a,
  input  logic [FLOAT_LEN-1:0] b,
  input  logic op,
  input  logic lut_wr_en,
  input  logic lut_sel,
  input  logic [LUT_AW-1:0] lut_wr_addr,
  input  logic [MANT_LEN-1:0] lut_wr_data,
  output logic out_valid,
  input  logic out_ready,
  output logic [FLOAT_LEN-1:0] result
);
  localparam int BIAS = 2 ** (EXP_LEN - 1) - 1;
  localparam int EW = EXP_LEN + 2;
  localparam logic [EXP_LEN-1:0] EMAX = '1;
  localparam logic signed [EW-1:0] EF_INF = EW'(2 ** EXP_LEN - 1);
  localparam logic signed [EW-1:0] EF_SUB = EW'(1 - MANT_LEN);
  localparam logic signed [EW-1:0] EF_ZERO = '0;
  localparam logic signed [EW-1:0] EB = EW'(BIAS);
  logic [EXP_LEN-1:0] ea, eb;
  logic [MANT_LEN-1:0] ma, mb, la, lb, m_exp, exp_rd_unused;
  logic za, zb, ia, ib, na, nb;
  sp_e sp;
  logic s1_v, s1_s, s1_op, s2_v, s2_s;
  sp_e s1_sp, s2_sp;
  logic signed [EW-1:0] s1_ea, s1_eb, e_sum, ef, s2_ef;
  logic [MANT_LEN-1:0] s1_la, s1_lb, s2_m;
  logic [MANT_LEN:0] m_sum, sub_m;
  logic [FLOAT_LEN-1:0] pk;
  assign ea = a[FLOAT_LEN-2 -: EXP_LEN];
  assign eb = b[FLOAT_LEN-2 -: EXP_LEN];
  assign ma = a[MANT_LEN-1:0];
  assign mb = b[MANT_LEN-1:0];
  // subnormal inputs (exp == 0) are flushed, so they classify as zero
  assign za = ea == '0;
  assign zb = eb == '0;
  assign ia = ea == EMAX && ma == '0;
  assign ib = eb == EMAX && mb == '0;
  assign na = ea == EMAX && ma != '0;
  assign nb = eb == EMAX && mb != '0;
  always_comb
    sp = (na || nb || (op == OP_MUL ? (za && ib) || (ia && zb) : (ia && ib) || (za && zb))) ? SP_NAN :
         (op == OP_MUL ? ia || ib : ia || zb) ? SP_INF :
         (op == OP_MUL ? za || zb : za || ib) ? SP_ZERO : SP_NONE;
  lut_ram_2r1w #(.DEPTH(2 ** LUT_AW), .WIDTH(MANT_LEN)) u_log2 (
    .clk(clk), .wr_en(lut_wr_en && lut_sel == LUT_LOG2), .wr_addr(lut_wr_addr), .wr_data(lut_wr_data),
    .rd_addr0(ma[MANT_LEN-1 -: LUT_AW]), .rd_addr1(mb[MANT_LEN-1 -: LUT_AW]),
    .rd_data0(la), .rd_data1(lb)
  );
  // carry out of the log-mantissa sum (or borrow of the difference) moves the exponent by one
  assign m_sum = s1_op == OP_DIV ? {1'b0, s1_la} - {1'b0, s1_lb} : {1'b0, s1_la} + {1'b0, s1_lb};
  assign e_sum = s1_op == OP_DIV ? s1_ea - s1_eb - EW'(m_sum[MANT_LEN]) : s1_ea + s1_eb + EW'(m_sum[MANT_LEN]);
  assign ef = e_sum + EB;
  lut_ram_2r1w #(.DEPTH(2 ** LUT_AW), .WIDTH(MANT_LEN)) u_exp2 (
    .clk(clk), .wr_en(lut_wr_en && lut_sel == LUT_EXP2), .wr_addr(lut_wr_addr), .wr_data(lut_wr_data),
    .rd_addr0(m_sum[MANT_LEN-1 -: LUT_AW]), .rd_addr1(m_sum[MANT_LEN-1 -: LUT_AW]),
    .rd_data0(m_exp), .rd_data1(exp_rd_unused)
  );
  assign sub_m = {1'b1, s2_m} >> (EW'(1) - s2_ef);
  assign pk = s2_sp == SP_NAN ? {s2_s, EMAX, 1'b1, (MANT_LEN-1)'(0)} :
              (s2_sp == SP_INF || s2_ef >= EF_INF) ? {s2_s, EMAX, MANT_LEN'(0)} :
              (s2_sp == SP_ZERO || s2_ef < EF_SUB) ? {s2_s, (FLOAT_LEN-1)'(0)} :
              s2_ef <= EF_ZERO ? {s2_s, EXP_LEN'(0), sub_m[MANT_LEN-1:0]} :
              {s2_s, s2_ef[EXP_LEN-1:0], s2_m};
  assign in_ready = !out_valid || out_ready;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1_v <= 1'b0;
      s2_v <= 1'b0;
      out_valid <= 1'b0;
      result <= '0;
    end else if (in_ready) begin
      s1_v <= in_valid;
      s2_v <= s1_v;
      out_valid <= s2_v;
      if (s2_v) result <= pk;
    end
  always_ff @(posedge clk)
    if (in_ready) begin
      s1_s <= a[FLOAT_LEN-1] ^ b[FLOAT_LEN-1];
      s1_op <= op;
      s1_sp <= sp;
      s1_ea <= EW'(ea) - EB;
      s1_eb <= EW'(eb) - EB;
      s1_la <= la;
      s1_lb <= lb;
      s2_s <= s1_s;
      s2_sp <= s1_sp;
      s2_ef <= ef;
      s2_m <= m_exp;
    end
endmodule

// File: tb/tb_log_scale_muldiv.sv
// tb_log_scale_muldiv: randomized and directed checks of log_scale_muldiv against an integer reference model
`timescale 1ns/1ps
module tb_log_scale_muldiv;
  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid = 1'b0, in_ready, op = 1'b0;
  logic [15:0] a_i = '0, b_i = '0, result;
  logic lut_wr_en = 1'b0, lut_sel = 1'b0;
  logic [6:0] lut_wr_addr = '0;
  logic [9:0] lut_wr_data = '0;
  logic out_valid, out_ready = 1'b0;
  int n_cmp = 0, n_fail = 0;
  int tl [128];
  int te [128];

  log_scale_muldiv dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a_i), .b(b_i), .op(op),
    .lut_wr_en(lut_wr_en), .lut_sel(lut_sel), .lut_wr_addr(lut_wr_addr), .lut_wr_data(lut_wr_data),
    .out_valid(out_valid), .out_ready(out_ready), .result(result)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] ref_model(input logic [15:0] x, input logic [15:0] y, input logic o);
    int ex, ey, mx, my, e, m, ef, mr;
    logic s;
    bit zx, zy, ix, iy, nx, ny;
    s = x[15] ^ y[15];
    ex = int'(x[14:10]); ey = int'(y[14:10]);
    mx = int'(x[9:0]); my = int'(y[9:0]);
    zx = ex == 0; zy = ey == 0;
    ix = ex == 31 && mx == 0; iy = ey == 31 && my == 0;
    nx = ex == 31 && mx != 0; ny = ey == 31 && my != 0;
    if (nx || ny || (!o && ((zx && iy) || (ix && zy))) || (o && ((ix && iy) || (zx && zy))))
      return {s, 15'h7E00};
    if (!o ? (ix || iy) : (zy || ix)) return {s, 15'h7C00};
    if (!o ? (zx || zy) : (zx || iy)) return {s, 15'h0000};
    m = o ? tl[mx >> 3] - tl[my >> 3] : tl[mx >> 3] + tl[my >> 3];
    e = o ? (ex - 15) - (ey - 15) : (ex - 15) + (ey - 15);
    if (m >= 1024) begin m -= 1024; e++; end
    if (m < 0) begin m += 1024; e--; end
    ef = e + 15;
    mr = te[m >> 3];
    if (ef >= 31) return {s, 15'h7C00};
    if (ef < -9) return {s, 15'h0000};
    if (ef <= 0) return {s, 5'd0, 10'((1024 + mr) >> (1 - ef))};
    return {s, 5'(ef), 10'(mr)};
  endfunction

  function automatic logic [15:0] gen_fp();
    int k;
    logic s;
    k = $urandom_range(0, 11);
    s = 1'($urandom_range(0, 1));
    if (k == 0) return {s, 15'h0000};
    if (k == 1) return {s, 15'h7C00};
    if (k == 2) return {s, 5'h1F, 10'($urandom_range(1, 1023))};
    if (k == 3) return {s, 5'h00, 10'($urandom_range(1, 1023))};
    return {s, 5'($urandom_range(1, 30)), 10'($urandom)};
  endfunction

  task automatic load_tables(input bit rnd);
    for (int t = 0; t < 2; t++)
      for (int i = 0; i < 128; i++) begin
        lut_wr_en = 1'b1;
        lut_sel = 1'(t);
        lut_wr_addr = 7'(i);
        lut_wr_data = rnd ? 10'($urandom) : 10'(i << 3);
        if (t == 0) tl[i] = int'(lut_wr_data); else te[i] = int'(lut_wr_data);
        cyc();
      end
    lut_wr_en = 1'b0;
  endtask

  task automatic run_op(input logic [15:0] x, input logic [15:0] y, input logic o, input bit wr,
                        output logic [15:0] r, output int lat);
    a_i = x; b_i = y; op = o; in_valid = 1'b1; out_ready = 1'b1;
    lut_wr_en = wr; lut_sel = 1'b0; lut_wr_addr = 7'd0; lut_wr_data = 10'h3F8;
    cyc();
    in_valid = 1'b0; lut_wr_en = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin cyc(); lat++; end
    r = result;
    cyc();
  endtask

  task automatic test_reset;
    #3;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (result !== 16'h0) begin n_fail++; $display("FAIL reset_result: got %h want 0000", result); end
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_directed;
    logic [15:0] va [9] = '{16'h4000, 16'h4800, 16'hC000, 16'h7C00, 16'h3C00, 16'h0000, 16'h7800, 16'h0400, 16'h0400};
    logic [15:0] vb [9] = '{16'h4400, 16'h4000, 16'h4000, 16'h0000, 16'h0000, 16'h7C00, 16'h7800, 16'h3800, 16'h0400};
    logic vo [9] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [15:0] ve [9] = '{16'h4800, 16'h4400, 16'hBC00, 16'h7E00, 16'h7C00, 16'h0000, 16'h7C00, 16'h0200, 16'h0000};
    logic [15:0] r;
    int lat;
    for (int i = 0; i < 9; i++) begin
      run_op(va[i], vb[i], vo[i], 1'b0, r, lat);
      n_cmp++; if (r !== ve[i]) begin n_fail++; $display("FAIL directed_%0d result: got %h want %h", i, r, ve[i]); end
      n_cmp++; if (lat !== 3) begin n_fail++; $display("FAIL directed_%0d latency: got %0d want 3", i, lat); end
    end
  endtask

  task automatic test_lut_write;
    logic [15:0] e_old, e_new, r;
    int lat;
    e_old = ref_model(16'h4000, 16'h4400, 1'b0);
    run_op(16'h4000, 16'h4400, 1'b0, 1'b1, r, lat);
    tl[0] = 10'h3F8;
    n_cmp++; if (r !== e_old) begin n_fail++; $display("FAIL lut_same_cycle_old: got %h want %h", r, e_old); end
    e_new = ref_model(16'h4000, 16'h4400, 1'b0);
    run_op(16'h4000, 16'h4400, 1'b0, 1'b0, r, lat);
    n_cmp++; if (r !== e_new) begin n_fail++; $display("FAIL lut_after_write_new: got %h want %h", r, e_new); end
  endtask

  task automatic test_random;
    logic [15:0] q [$];
    logic [15:0] exp_v, held;
    int sent = 0, got = 0, cycles = 0;
    bit stalled = 0;
    while ((sent < 300 || got < sent) && cycles < 4000) begin
      in_valid = sent < 300 && $urandom_range(0, 3) != 0;
      a_i = gen_fp(); b_i = gen_fp(); op = 1'($urandom_range(0, 1));
      out_ready = $urandom_range(0, 3) != 0;
      @(negedge clk);
      if (stalled) begin
        n_cmp++;
        if (out_valid !== 1'b1 || result !== held) begin
          n_fail++; $display("FAIL rand_stall_stable: got v=%b %h want v=1 %h", out_valid, result, held);
        end
      end
      stalled = out_valid && !out_ready;
      held = result;
      if (in_valid && in_ready) begin q.push_back(ref_model(a_i, b_i, op)); sent++; end
      if (out_valid && out_ready) begin
        exp_v = q.size() > 0 ? q.pop_front() : 16'hxxxx;
        n_cmp++; if (result !== exp_v) begin n_fail++; $display("FAIL rand_result_%0d: got %h want %h", got, result, exp_v); end
        got++;
      end
      cyc();
      cycles++;
    end
    in_valid = 1'b0;
    n_cmp++; if (got !== 300) begin n_fail++; $display("FAIL rand_count: got %0d results want 300", got); end
  endtask

  task automatic test_back_to_back;
    logic [15:0] va [4], vb [4], exp_q [$], held, exp_v;
    logic vo [4];
    int k = 0, got = 0, unstable = 0;
    bit seen = 0;
    for (int i = 0; i < 4; i++) begin
      va[i] = {1'($urandom_range(0, 1)), 5'($urandom_range(8, 22)), 10'($urandom)};
      vb[i] = {1'($urandom_range(0, 1)), 5'($urandom_range(8, 22)), 10'($urandom)};
      vo[i] = 1'($urandom_range(0, 1));
    end
    out_ready = 1'b0;
    for (int c = 0; c < 8; c++) begin
      in_valid = k < 4;
      if (k < 4) begin a_i = va[k]; b_i = vb[k]; op = vo[k]; end
      @(negedge clk);
      if (seen && result !== held) unstable++;
      if (out_valid && !seen) begin seen = 1; held = result; end
      if (in_valid && in_ready) begin exp_q.push_back(ref_model(va[k], vb[k], vo[k])); k++; end
      cyc();
    end
    @(negedge clk);
    n_cmp++; if (k !== 3) begin n_fail++; $display("FAIL b2b_accepted_while_stalled: got %0d want 3", k); end
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_in_ready_full: got %b want 0", in_ready); end
    n_cmp++; if (unstable !== 0) begin n_fail++; $display("FAIL b2b_result_stable: got %0d changes want 0", unstable); end
    n_cmp++; if (out_valid !== 1'b1 || result !== exp_q[0]) begin
      n_fail++; $display("FAIL b2b_head_held: got v=%b %h want v=1 %h", out_valid, result, exp_q[0]);
    end
    cyc();
    out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      in_valid = k < 4;
      if (k < 4) begin a_i = va[k]; b_i = vb[k]; op = vo[k]; end
      @(negedge clk);
      if (in_valid && in_ready) begin exp_q.push_back(ref_model(va[k], vb[k], vo[k])); k++; end
      if (out_valid) begin
        exp_v = exp_q.size() > 0 ? exp_q.pop_front() : 16'hxxxx;
        n_cmp++; if (result !== exp_v) begin n_fail++; $display("FAIL b2b_order_%0d: got %h want %h", got, result, exp_v); end
        got++;
      end
      cyc();
    end
    in_valid = 1'b0;
    n_cmp++; if (got !== 4) begin n_fail++; $display("FAIL b2b_count: got %0d want 4", got); end
  endtask

  task automatic test_reset_flight;
    int extra = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a_i = 16'h4000; b_i = 16'h4400; op = 1'b0; in_valid = 1'b1;
      cyc();
    end
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL flight_before_reset: got %b want 1", out_valid); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flight_reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (result !== 16'h0) begin n_fail++; $display("FAIL flight_reset_result: got %h want 0000", result); end
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flight_reset_in_ready: got %b want 1", in_ready); end
    cyc(); cyc();
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (out_valid) extra++;
      cyc();
    end
    n_cmp++; if (extra !== 0) begin n_fail++; $display("FAIL flight_stale_output: got %0d outputs want 0", extra); end
  endtask

  initial begin
    test_reset;
    load_tables(1'b0);
    test_directed;
    test_lut_write;
    load_tables(1'b1);
    test_random;
    load_tables(1'b0);
    test_back_to_back;
    test_reset_flight;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/log_scale_muldiv.md
LOG_SCALE_MULDIV -- requirements
Module: log_scale_muldiv

Interface
REQ-001 The block SHALL have parameter EXP_LEN, default 5, meaning exponent width.
REQ-002 The block SHALL have parameter MANT_LEN, default 10, meaning stored mantissa width.
REQ-003 The block SHALL have parameter LUT_AW, default 7, meaning LUT address width; depth is 2^LUT_AW and LUT_AW <= MANT_LEN.
REQ-004 The block SHALL derive FLOAT_LEN = 1+EXP_LEN+MANT_LEN and BIAS = 2^(EXP_LEN-1)-1.
REQ-005 The block SHALL have port clk, input, 1 bit: clock.
REQ-006 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-007 The block SHALL have port in_valid, input, 1 bit: operand pair valid.
REQ-008 The block SHALL have port in_ready, output, 1 bit: block accepts operands.
REQ-009 The block SHALL have ports a and b, input, FLOAT_LEN bits each: operands.
REQ-010 The block SHALL have port op, input, 1 bit: 0 = a*b, 1 = a/b.
REQ-011 The block SHALL have ports lut_wr_en (1 bit), lut_sel (1 bit: 0 = log2 table, 1 = exp2 table), lut_wr_addr (LUT_AW bits) and lut_wr_data (MANT_LEN bits), all inputs.
REQ-012 The block SHALL have port out_valid, output, 1 bit: result valid.
REQ-013 The block SHALL have port out_ready, input, 1 bit: consumer accepts result.
REQ-014 The block SHALL have port result, output, FLOAT_LEN bits: a op b.

Function
REQ-015 Transfers SHALL follow valid/ready rules: input transfer on in_valid&&in_ready; output transfer on out_valid&&out_ready.
REQ-016 The pipeline SHALL have 3 stages (S1 unpack/log2 lookup, S2 add-or-subtract/normalise/exp2 lookup, S3 pack/special-case select), each with a valid bit.
REQ-017 Latency SHALL be 3 cycles from input transfer to out_valid when there is no backpressure; throughput SHALL be 1 per cycle.
REQ-018 Stall rule: in_ready = !S3_valid || out_ready; when in_ready is 0, all stages SHALL hold, and result/out_valid SHALL stay stable until the output transfer.
REQ-019 Bubbles SHALL advance: an empty stage SHALL be filled whenever the pipeline is not stalled.
REQ-020 Log2 path: index = mant[MANT_LEN-1 -: LUT_AW]; both operands SHALL read the single log2 table in the same cycle (2 read ports).
REQ-021 Multiply: E = ea+eb; M = La+Lb (MANT_LEN+1 bits); a carry SHALL increment E, and M SHALL be taken mod 2^MANT_LEN.
REQ-022 Divide: E = ea-eb; M = La-Lb; a borrow SHALL decrement E, and M SHALL be taken mod 2^MANT_LEN.
REQ-023 Exponent arithmetic SHALL be signed and EXP_LEN+2 bits wide; the biased exponent SHALL be Ef = E+BIAS.
REQ-024 The exp2 table, indexed by M[MANT_LEN-1 -: LUT_AW], SHALL give the result mantissa.
REQ-025 Packing: Ef >= 2^EXP_LEN-1 SHALL give +/-inf; 1-MANT_LEN <= Ef <= 0 SHALL give a subnormal {1,mant} >> (1-Ef); Ef < 1-MANT_LEN SHALL give signed zero; otherwise the result SHALL be normal.
REQ-026 Sign SHALL be sa^sb in all cases, including specials.
REQ-027 Subnormal inputs SHALL be flushed to zero.
REQ-028 Specials, in priority order: NaN input, 0*inf, inf/inf and 0/0 SHALL give qNaN (exp all-ones, mant MSB set); otherwise inf*x, x/0 and inf/x SHALL give inf; otherwise 0*x, 0/x and x/inf SHALL give zero.
REQ-029 LUT writes SHALL be accepted in any cycle, independent of the handshake, with one-cycle write latency; a same-cycle read of the written address SHALL return the old data.

Reset
REQ-030 On rst_n low, all valid bits, out_valid and result SHALL go to 0 immediately, and in_ready SHALL be 1.
REQ-031 Reset mid-operation SHALL discard all in-flight operations with no output.
REQ-032 LUT contents SHALL NOT be reset; the tables SHALL be reloaded after power-up.

Structure
REQ-033 Package log_scale_pkg SHALL hold the default parameters, the fp16 field-width constants, the QNAN/INF constants, the op encoding and the lut_sel encoding.
REQ-034 Sub-module lut_ram_2r1w (parametrised depth/width, 1 write port, 2 read ports) SHALL be used; it SHALL be instantiated for the log2 table (2 reads) and for the exp2 table (1 read used).

Verification
REQ-035 Identity tables loaded (log2[0] = 0, exp2[0] = 0): a=0x4000, b=0x4400, op=0 -> 0x4800 exactly 3 cycles later.
REQ-036 Same tables: a=0x4800, b=0x4000, op=1 -> 0x4400; a=0xC000, b=0x4000, op=1 -> 0xBC00.
REQ-037 Specials: 0x7C00*0x0000 -> 0x7E00; 0x3C00/0x0000 -> 0x7C00; 0x0000/0x7C00 -> 0x0000; 0x7800*0x7800 -> 0x7C00.
REQ-038 Back-to-back 4 ops with out_ready held 0: in_ready SHALL drop once the pipe is full, result SHALL stay stable, and on release all 4 results SHALL emerge in order with none lost or duplicated.
REQ-039 Assert rst_n low with 3 ops in flight: out_valid SHALL be 0 immediately, and no stale result SHALL appear after release.
REQ-040 Underflow: 0x0400 (2^-14) * 0x3800 (0.5) -> 0x0200 subnormal; 0x0400*0x0400 -> 0x0000.
